linebuf_reader: RTL and testbench
=================================

Name: linebuf_reader

Overview:
- Downstream consumer of the single-clock dual-port line/scratch RAM (synchronous read, one-cycle read latency).
- On a start command, reads `length` consecutive words from a base address.
- Presents the words as a valid/ready stream to the next stage (pixel serializer, SPI/UART transmitter).
- Absorbs the RAM read latency with a two-entry buffer so back-pressure never loses data.

Parameters:
WIDTH, 9, data word width in bits; must match RAM port width
DEPTH, 9, address width in bits; RAM holds 2^DEPTH words

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
base_addr  input  DEPTH  first RAM address, latched on accepted start
length  input  DEPTH+1  number of words, 0..2^DEPTH, latched on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the transfer completes
ram_addr  output  DEPTH  read address to RAM read port
ram_dout  input  WIDTH  RAM read data, valid the cycle after ram_addr is sampled
out_data  output  WIDTH  stream data (head of buffer)
out_valid  output  1  stream data valid
out_ready  input  1  downstream accepts when out_valid and out_ready are both high
out_last  output  1  qualifies the final word of a transfer

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: busy=0, done=0, out_valid=0, out_last=0, ram_addr=0, out_data=0, buffer count=0, in-flight flag=0, state=IDLE.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 latches base_addr into the address counter and length into the remaining counter.
  - If length=0: stay IDLE, pulse done next cycle, busy stays 0, nothing is streamed.
  - Otherwise go to RUN; busy=1 from the next cycle.
- RUN:
  - Issue a read when remaining>0 and (count + inflight − pop) < 2, where pop = out_valid & out_ready this cycle.
  - An issue drives ram_addr=address counter, sets inflight for the next cycle, increments the address modulo 2^DEPTH (wraps 2^DEPTH−1 → 0), and decrements remaining.
  - When remaining reaches 0 after an issue, go to FLUSH.
- FLUSH:
  - No new reads are issued; wait until inflight=0 and count=0.
  - Then done=1 for exactly one cycle, busy=0 the same cycle, return to IDLE.
- Read latency: inflight=1 means ram_dout is valid this cycle; it is written into the buffer at the next edge. Simultaneous push and pop is allowed; count stays unchanged.
- Timing with out_ready held high: start sampled at edge E0; ram_addr=base during cycle E0..E1; out_valid first high after E2. Sustained rate is 1 word/clock thereafter.
- Back-pressure:
  - While out_valid=1 and out_ready=0, out_data and out_last must hold stable.
  - The credit rule guarantees the buffer never overflows. No word is dropped or duplicated.
- out_last is tagged at issue time on the read that takes remaining from 1 to 0, travels with its word, and is set only while that word is at the head.
- start while busy=1 is ignored, with no effect on the counters.
- Reset mid-transfer: the transfer is abandoned, the buffer is emptied, any in-flight RAM data is discarded, done is not pulsed.
- ram_addr holds its last value when no read is issued; the RAM read port has no enable.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_FLUSH) and buffer depth constant (2).
- One sub-module, skid_fifo2:
  - two-entry WIDTH+1 bit FIFO (data plus last flag)
  - push/pop/count interface
  - simultaneous push/pop supported
  - count output used for the credit check.

Test Plan:
- Reset, then start base=0x010, length=4, out_ready=1, RAM[i]=i → first out_valid 3 edges after start; words 0x010..0x013 on consecutive cycles; out_last on 0x013; done pulses one cycle after the last handshake.
- start length=0 → no out_valid, done pulse next cycle, busy never asserted.
- base=0x1FE, length=4 (DEPTH=9) → ram_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; data order preserved.
- length=8 with out_ready toggling 1,0,0,1,1,0 repeating → all 8 words delivered exactly once, in order; data held stable while stalled; ram_addr never issued with count+inflight=2.
- reset asserted two cycles into a length=16 transfer → next cycle out_valid=0, busy=0, no done; a fresh start then works normally from its new base.
- start pulsed again mid-transfer with a different base/length → ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/linebuf_reader_pkg.sv
// Shared FSM encoding, buffer sizing and read-credit helper for the line-buffer reader.
package linebuf_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;

    // Words held plus the one arriving from RAM, less the one leaving, must stay below BUF_DEPTH.
    function automatic logic has_credit(input logic [1:0] count,
                                        input logic       inflight,
                                        input logic       pop);
        return ({1'b0, count} + {2'b00, inflight}) < (3'(BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO absorbing the RAM read latency; entry0 is always the head of the queue.
module skid_fifo2
    import linebuf_reader_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         do_pop;
    logic         do_push;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != FULL) || do_pop);
    assign head_data = entry0;

    // On a simultaneous push and pop the new word lands behind whatever remains.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0)
                        entry0 <= push_data;
                    else
                        entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/linebuf_reader.sv
// Reads a run of consecutive words from a synchronous RAM and streams them out as valid/ready,
// issuing reads only when the two-entry buffer is guaranteed room for the returning word.
module linebuf_reader
    import linebuf_reader_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] base_addr,
    input  logic [DEPTH:0]   length,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] ram_addr,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    state_t           state;
    state_t           state_next;
    logic [DEPTH-1:0] addr_cnt;
    logic [DEPTH-1:0] ram_addr_q;
    logic [DEPTH:0]   remaining;
    logic             inflight;
    logic             inflight_last;
    logic             zero_done;
    logic [1:0]       buf_count;
    logic [WIDTH:0]   head;
    logic             pop;
    logic             issue;
    logic             accept;
    logic             drained;

    assign pop       = out_valid && out_ready;
    assign out_valid = (buf_count != 2'd0);
    assign out_data  = head[WIDTH-1:0];
    assign out_last  = out_valid && head[WIDTH];
    assign drained   = !inflight && (buf_count == 2'd0);

    // The RAM has no read enable, so the address is held between issues.
    assign ram_addr  = issue ? addr_cnt : ram_addr_q;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = zero_done;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length != '0)
                        state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((remaining != '0) && has_credit(buf_count, inflight, pop)) begin
                    issue = 1'b1;
                    if (remaining == (DEPTH+1)'(1))
                        state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (drained) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The last flag is captured at issue time so it travels with its word through the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_cnt      <= '0;
            ram_addr_q    <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            state      <= state_next;
            zero_done  <= accept && (length == '0);
            inflight   <= issue;
            ram_addr_q <= ram_addr;
            if (accept) begin
                addr_cnt  <= base_addr;
                remaining <= length;
            end else if (issue) begin
                addr_cnt  <= addr_cnt + DEPTH'(1);
                remaining <= remaining - (DEPTH+1)'(1);
            end
            if (issue)
                inflight_last <= (remaining == (DEPTH+1)'(1));
        end
    end

    skid_fifo2 #(
        .W(WIDTH + 1)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data({inflight_last, ram_dout}),
        .pop      (pop),
        .head_data(head),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_linebuf_reader.sv
// Scoreboard bench for linebuf_reader: expected words are queued at start and popped on handshakes.
module tb_linebuf_reader;

    localparam int WIDTH = 9;
    localparam int DEPTH = 9;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             start     = 1'b0;
    logic             out_ready = 1'b0;
    logic [DEPTH-1:0] base_addr = '0;
    logic [DEPTH:0]   length    = '0;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             out_last;
    logic [DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_dout;
    logic [WIDTH-1:0] out_data;

    logic [WIDTH-1:0] ram [0:(1<<DEPTH)-1];
    logic [WIDTH:0]   exp_q[$];
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= ram[ram_addr];

    linebuf_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    task automatic step(input logic rdy);
        @(negedge clk);
        start     = 1'b0;
        out_ready = rdy;
        #1;
    endtask

    task automatic issue_start(input logic [DEPTH-1:0] b, input logic [DEPTH:0] n);
        start     = 1'b1;
        base_addr = b;
        length    = n;
    endtask

    task automatic push_expected(input logic [DEPTH-1:0] b, input int n);
        logic [DEPTH-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + DEPTH'(i);
            exp_q.push_back({(i == n - 1), ram[a]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (ram_addr !== 9'h000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", ram_addr); end
        checks++; if (out_data !== 9'h000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", out_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int first_valid, last_hs, done_cyc, ndone;
        logic [WIDTH:0] exp_w;
        first_valid = -1; last_hs = -1; done_cyc = -1; ndone = 0;
        exp_q.delete();
        step(1'b1);
        issue_start(9'h010, 10'd4);
        push_expected(9'h010, 4);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step(1'b1);
            if (cyc <= 4) begin
                checks++;
                if (ram_addr !== 9'h010 + 9'(cyc - 1)) begin
                    errors++; $display("[TB] FAIL basic_addr cyc%0d: got %h expected %h", cyc, ram_addr, 9'h010 + 9'(cyc - 1));
                end
            end
            if (cyc == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                last_hs = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL basic_word: got extra %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++; $display("[TB] FAIL basic_word: got %h expected %h", {out_last, out_data}, exp_w);
                    end
                end
            end
            if (done) begin
                ndone++; done_cyc = cyc;
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
            end
        end
        checks++; if (first_valid != 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", first_valid); end
        checks++; if (done_cyc != last_hs + 1) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_cyc, last_hs + 1); end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", ndone); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL basic_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_zero_length();
        int ndone, done_cyc;
        ndone = 0; done_cyc = -1;
        step(1'b1);
        issue_start(9'h055, 10'd0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            step(1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid cyc%0d: got %b expected 0", cyc, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy cyc%0d: got %b expected 0", cyc, busy); end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        checks++; if (done_cyc != 1) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_wrap();
        logic [DEPTH-1:0] exp_addr [4];
        logic [WIDTH:0]   exp_w;
        int ndone;
        exp_addr[0] = 9'h1FE; exp_addr[1] = 9'h1FF; exp_addr[2] = 9'h000; exp_addr[3] = 9'h001;
        ndone = 0;
        exp_q.delete();
        step(1'b1);
        issue_start(9'h1FE, 10'd4);
        push_expected(9'h1FE, 4);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step(1'b1);
            if (cyc <= 4) begin
                checks++;
                if (ram_addr !== exp_addr[cyc - 1]) begin
                    errors++; $display("[TB] FAIL wrap_addr cyc%0d: got %h expected %h", cyc, ram_addr, exp_addr[cyc - 1]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL wrap_word: got extra %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++; $display("[TB] FAIL wrap_word: got %h expected %h", {out_last, out_data}, exp_w);
                    end
                end
            end
            if (done) ndone++;
        end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL wrap_done_count: got %0d expected 1", ndone); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [DEPTH-1:0] prev_addr;
        logic [WIDTH:0]   held, exp_w;
        logic             have_held, rdy;
        int issued, popped, ndone, k;
        issued = 0; popped = 0; ndone = 0; have_held = 1'b0; held = '0;
        exp_q.delete();
        step(1'b1);
        issue_start(9'h040, 10'd8);
        push_expected(9'h040, 8);
        prev_addr = ram_addr;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            k   = (cyc - 1) % 6;
            rdy = (k == 0) || (k == 3) || (k == 4);
            step(rdy);
            if (ram_addr !== prev_addr) begin
                checks++;
                if ((issued - popped - ((out_valid && out_ready) ? 1 : 0)) >= 2) begin
                    errors++; $display("[TB] FAIL bp_credit cyc%0d: got %0d outstanding expected below 2", cyc, issued - popped);
                end
                checks++;
                if (ram_addr !== 9'h040 + 9'(issued)) begin
                    errors++; $display("[TB] FAIL bp_addr cyc%0d: got %h expected %h", cyc, ram_addr, 9'h040 + 9'(issued));
                end
                issued++;
            end
            prev_addr = ram_addr;
            if (have_held && out_valid) begin
                checks++;
                if ({out_last, out_data} !== held) begin
                    errors++; $display("[TB] FAIL bp_hold cyc%0d: got %h expected %h", cyc, {out_last, out_data}, held);
                end
            end
            have_held = out_valid && !out_ready;
            held      = {out_last, out_data};
            if (out_valid && out_ready) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL bp_word: got extra %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++; $display("[TB] FAIL bp_word: got %h expected %h", {out_last, out_data}, exp_w);
                    end
                end
            end
            if (done) ndone++;
        end
        checks++; if (issued != 8) begin errors++; $display("[TB] FAIL bp_issue_count: got %0d expected 8", issued); end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", ndone); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH:0] exp_w;
        int ndone;
        ndone = 0;
        exp_q.delete();
        step(1'b1);
        issue_start(9'h080, 10'd16);
        step(1'b1);
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done: got %b expected 0", done); end
        checks++; if (ram_addr !== 9'h000) begin errors++; $display("[TB] FAIL rmid_addr: got %h expected 000", ram_addr); end
        reset = 1'b0;
        for (int cyc = 4; cyc <= 7; cyc++) begin
            step(1'b1);
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL rmid_quiet cyc%0d: got valid=%b done=%b busy=%b expected all 0", cyc, out_valid, done, busy);
            end
        end
        step(1'b1);
        issue_start(9'h0C0, 10'd3);
        push_expected(9'h0C0, 3);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step(1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL rmid_word: got extra %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++; $display("[TB] FAIL rmid_word: got %h expected %h", {out_last, out_data}, exp_w);
                    end
                end
            end
            if (done) ndone++;
        end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL rmid_done_count: got %0d expected 1", ndone); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_start_ignored();
        logic [WIDTH:0] exp_w;
        int ndone, done_cyc;
        ndone = 0; done_cyc = -1;
        exp_q.delete();
        step(1'b1);
        issue_start(9'h100, 10'd6);
        push_expected(9'h100, 6);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step(1'b1);
            if (cyc == 2) issue_start(9'h1F0, 10'd3);
            if (cyc <= 6) begin
                checks++;
                if (ram_addr !== 9'h100 + 9'(cyc - 1)) begin
                    errors++; $display("[TB] FAIL ign_addr cyc%0d: got %h expected %h", cyc, ram_addr, 9'h100 + 9'(cyc - 1));
                end
            end
            if (cyc >= 11) begin
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("[TB] FAIL ign_idle cyc%0d: got valid=%b busy=%b expected 0 0", cyc, out_valid, busy);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL ign_word: got extra %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++; $display("[TB] FAIL ign_word: got %h expected %h", {out_last, out_data}, exp_w);
                    end
                end
            end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("[TB] FAIL ign_done_cycle: got %0d expected 9", done_cyc); end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL ign_done_count: got %0d expected 1", ndone); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL ign_missing: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) ram[i] = WIDTH'(i);
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
